// File: rtl/gshare_predictor_pkg.sv
// Shared lc3b types used by the gshare predictor.
//   lc3b_word     : 16-bit machine word (PC width)
//   lc3b_pht_ctr  : pattern-history counter at the default 2-bit width
//   PHT_CTR_INIT  : weakly-taken reset value at the default width
package gshare_predictor_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_pht_ctr;

  localparam lc3b_pht_ctr PHT_CTR_INIT = 2'b10;

endpackage

// File: rtl/sat_counter_update.sv
// Combinational next-value for a saturating up/down counter.
// Ports:
//   count      in  CTR_BITS  current counter value
//   taken      in  1         1 = count up, 0 = count down
//   next_count out CTR_BITS  saturated result (clamps at 0 and 2^CTR_BITS-1)
module sat_counter_update #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] count,
  input  logic                taken,
  output logic [CTR_BITS-1:0] next_count
);

  localparam logic [CTR_BITS-1:0] CtrMax = {CTR_BITS{1'b1}};

  always_comb begin
    next_count = count;
    if (taken) begin
      if (count != CtrMax) next_count = count + 1'b1;
    end else begin
      if (count != '0) next_count = count - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor with its own speculative global history.
// Lookup is combinational; training and history repair come from writeback
// using the checkpoint (index, history) handed out at lookup.
// Optional statistics counters are built when GSHARE_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   lookup_valid, lookup_pc       fetch-side lookup request
//   predict_taken                 counter MSB at the lookup index
//   predict_index, predict_hist   checkpoint for this lookup
//   update_valid, update_index,
//   update_hist, update_taken,
//   update_mispredict             writeback training / GHR repair
//   stat_lookups, stat_mispredicts  16-bit saturating statistics
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned HIST_BITS  = 4,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned PC_LSB     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  lc3b_word              lookup_pc,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] predict_index,
  output logic [HIST_BITS-1:0]  predict_hist,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic [HIST_BITS-1:0]  update_hist,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  output logic [15:0]           stat_lookups,
  output logic [15:0]           stat_mispredicts
);

  localparam int Depth = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CtrInit = {1'b1, {(CTR_BITS-1){1'b0}}};

  logic [CTR_BITS-1:0]   table_q [Depth];
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0]   ctr_next;

  // Upper PC bits and the oldest checkpointed history bit never reach the logic.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc, update_hist};

  // History zero-extended to the index width before the XOR.
  assign lookup_idx    = lookup_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr_q);
  assign predict_taken = table_q[lookup_idx][CTR_BITS-1];
  assign predict_index = lookup_idx;
  assign predict_hist  = ghr_q;

  // Truncating {hist, bit} keeps the shift legal even when HIST_BITS == 1.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid && update_mispredict) begin
      ghr_d = HIST_BITS'({update_hist, update_taken});
    end else if (lookup_valid) begin
      ghr_d = HIST_BITS'({ghr_q, predict_taken});
    end
  end

  sat_counter_update #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter_update (
    .count      (table_q[update_index]),
    .taken      (update_taken),
    .next_count (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
      for (int i = 0; i < Depth; i++) table_q[i] <= CtrInit;
    end else begin
      ghr_q <= ghr_d;
      if (update_valid) table_q[update_index] <= ctr_next;
    end
  end

`ifdef GSHARE_STATS_EN
  logic [15:0] stat_lookups_q, stat_mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (lookup_valid && (stat_lookups_q != 16'hFFFF)) begin
        stat_lookups_q <= stat_lookups_q + 16'd1;
      end
      if (update_valid && update_mispredict && (stat_mispredicts_q != 16'hFFFF)) begin
        stat_mispredicts_q <= stat_mispredicts_q + 16'd1;
      end
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_lookups     = 16'h0000;
  assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised gshare direction predictor for the lc3b pipeline. Holds its own global history register (GHR) and a table of saturating counters indexed by PC XOR history.
- Fetch looks a branch up in the same cycle and receives a prediction plus a checkpoint (index and history). Writeback returns the checkpoint with the resolved outcome to train the counter and, on a mispredict, repair the GHR.
- Sits beside the BTB in fetch. Trained from the writeback stage.

Parameters:
- INDEX_BITS, 4: log2 of table depth; table has 2^INDEX_BITS entries.
- HIST_BITS, 4: GHR length. Legal range 1..INDEX_BITS. History is zero-extended to INDEX_BITS before the XOR.
- CTR_BITS, 2: counter width. Legal range 2..4.
- PC_LSB, 1: lowest PC bit used in the index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- lookup_valid  in  1  fetch is predicting a branch this cycle
- lookup_pc  in  lc3b_word  PC of the branch
- predict_taken  out  1  counter MSB at the lookup index (combinational)
- predict_index  out  INDEX_BITS  checkpoint: index used for this lookup
- predict_hist  out  HIST_BITS  checkpoint: GHR value before this lookup's shift
- update_valid  in  1  a resolved branch is training the table
- update_index  in  INDEX_BITS  index checkpointed at lookup
- update_hist  in  HIST_BITS  history checkpointed at lookup
- update_taken  in  1  resolved direction
- update_mispredict  in  1  prediction was wrong; repair the GHR
- stat_lookups  out  16  lookup count (optional feature)
- stat_mispredicts  out  16  mispredict count (optional feature)

Behaviour:
- Reset: every counter is set to 2^(CTR_BITS-1) (weakly taken, 2'b10 at default). GHR is cleared to 0. Reset clears the whole table in one cycle. Reset has priority over any lookup or update in the same cycle.
- Lookup is combinational, zero latency:
  - idx = lookup_pc[PC_LSB +: INDEX_BITS] ^ zext(GHR)
  - predict_taken = table[idx][CTR_BITS-1]
  - predict_index = idx; predict_hist = GHR
  - Outputs are valid whenever lookup_valid is high and are don't-care otherwise.
- Speculative history: on a clock edge with lookup_valid=1 and no repair, GHR <= {GHR[HIST_BITS-2:0], predict_taken}. When HIST_BITS=1, GHR <= predict_taken.
- Repair: on a clock edge with update_valid=1 and update_mispredict=1, GHR <= {update_hist[HIST_BITS-2:0], update_taken}. Repair overrides a simultaneous speculative shift, and that lookup's shift is discarded.
- Training: on update_valid, table[update_index] increments if update_taken, else decrements. It saturates at 0 and at 2^CTR_BITS-1. The new value is visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: the lookup sees the old counter value. There is no bypass.
- update_mispredict is ignored when update_valid=0.
- No backpressure. One lookup and one update are accepted per cycle.
- Index is computed from the checkpoint, never recomputed from the resolved PC, so training hits the entry that produced the prediction.

Optional Feature:
- Macro: GSHARE_STATS_EN.
- Defined:
  - stat_lookups increments on each lookup_valid.
  - stat_mispredicts increments on each update_valid & update_mispredict.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are present and tied to 16'h0000, and no counter flops are built.

Decomposition:
- lc3b_types gains:
  - typedef lc3b_pht_ctr (CTR_BITS-wide logic, default 2)
  - constant PHT_CTR_INIT = 2'b10
- One sub-module, sat_counter_update: combinational next-value function (count, taken) -> saturating count, parametrised by CTR_BITS. Instantiated once on the write port.
- GHR, table array and stats stay in gshare_predictor.

Test Plan (all at default parameters):
- Reset, then lookup_pc=16'h0004 -> predict_index=4'h2, predict_hist=4'h0, predict_taken=1. The next cycle GHR=4'b0001.
- Update idx 2 not-taken twice -> counter 10→01→00. Lookup pc=16'h0004 with GHR forced back to 0 via repair -> predict_taken=0.
- Update idx 5 taken three times -> counter 10→11→11→11. Then not-taken once -> 10, predict_taken stays 1.
- Two taken lookups take GHR to 4'b0011. In the same cycle as a third lookup, update_mispredict with update_hist=4'b0000 and update_taken=0 -> GHR=4'b0000 next cycle.
- Same-cycle lookup and update of idx 2 (not-taken, from 10) -> lookup returns taken=1. The following cycle returns taken=0.
- Assert rst mid-stream after training idx 2 to 00 -> idx 2 reads 10 and GHR reads 0. With GSHARE_STATS_EN, both stats read 0 after reset and then count 3 lookups / 1 mispredict.
